trace_filter_controller: RTL

Sequences trace capture around the trace_filter. It arms on a start PC and forwards instructions that the filter does not drop. It stops on a stop PC and accounts for items lost to downstream back-pressure. It sits between the CPU trace port plus trace_filter and the trace FIFO toward the host, and is configured at runtime through a small register-write port.

---
 rtl/trace_filter_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/trace_filter_controller.sv
// Trace capture sequencer: arms on a start PC and forwards items the filter keeps.
// It stops on a stop PC and counts items seen, forwarded, and lost to a full FIFO.
module trace_filter_controller #(
    parameter int unsigned PC_WIDTH      = 64,
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pc_valid,
    input  logic [PC_WIDTH-1:0]      pc,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     filter_drop,
    input  logic                     fifo_full,
    input  logic                     cfg_wr_en,
    input  logic [1:0]               cfg_addr,
    input  logic [PC_WIDTH-1:0]      cfg_wdata,
    output logic                     trace_valid,
    output logic [PC_WIDTH-1:0]      trace_pc,
    output logic [INSTR_WIDTH-1:0]   trace_instr,
    output logic [1:0]               state,
    output logic [COUNTER_WIDTH-1:0] seen_count,
    output logic [COUNTER_WIDTH-1:0] fwd_count,
    output logic [COUNTER_WIDTH-1:0] overflow_count
);

    localparam int unsigned CTRL_WIDTH = 3;
    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_START_PC = 2'd1;
    localparam logic [1:0] ADDR_STOP_PC  = 2'd2;
    localparam logic [1:0] ADDR_CLEAR    = 2'd3;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_STOPPED  = 2'd3
    } state_t;

    typedef struct packed {
        logic one_shot;
        logic pass_all;
        logic enable;
    } ctrl_t;

    state_t              cur_state;
    state_t              nxt_state;
    ctrl_t               ctrl_q;
    logic [PC_WIDTH-1:0] start_pc_q;
    logic [PC_WIDTH-1:0] stop_pc_q;

    logic wr_ctrl_c;
    logic wr_start_c;
    logic wr_stop_c;
    logic wr_clear_c;
    logic start_hit_c;
    logic stop_hit_c;
    logic item_c;
    logic keep_c;
    logic fwd_c;
    logic ovf_c;

    assign wr_ctrl_c   = cfg_wr_en && (cfg_addr == ADDR_CTRL);
    assign wr_start_c  = cfg_wr_en && (cfg_addr == ADDR_START_PC);
    assign wr_stop_c   = cfg_wr_en && (cfg_addr == ADDR_STOP_PC);
    assign wr_clear_c  = cfg_wr_en && (cfg_addr == ADDR_CLEAR);
    // A zero START_PC/STOP_PC means "no address match configured".
    assign start_hit_c = (start_pc_q != '0) && (pc == start_pc_q);
    assign stop_hit_c  = (stop_pc_q != '0) && (pc == stop_pc_q);

    assign state = cur_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_DISABLED;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and per-item decode; items always use the pre-write config
    always_comb begin
        nxt_state = cur_state;
        item_c    = 1'b0;
        keep_c    = 1'b0;
        fwd_c     = 1'b0;
        ovf_c     = 1'b0;
        case (cur_state)
            ST_DISABLED: begin
                if (wr_ctrl_c && cfg_wdata[0]) begin
                    nxt_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (pc_valid && start_hit_c) begin
                    item_c    = 1'b1;
                    nxt_state = ST_ACTIVE;
                end else if (start_pc_q == '0) begin
                    nxt_state = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                item_c = pc_valid;
            end
            ST_STOPPED: begin
                if (wr_clear_c && ctrl_q.enable) begin
                    nxt_state = ST_ARMED;
                end
            end
            default: begin
                nxt_state = ST_DISABLED;
            end
        endcase
        // Stop match ends the window after the item is processed
        if (item_c && stop_hit_c) begin
            nxt_state = ctrl_q.one_shot ? ST_STOPPED : ST_ARMED;
        end
        // Disable overrides everything else
        if (wr_ctrl_c && !cfg_wdata[0]) begin
            nxt_state = ST_DISABLED;
        end
        keep_c = item_c && (ctrl_q.pass_all || !filter_drop);
        fwd_c  = keep_c && !fifo_full;
        ovf_c  = keep_c && fifo_full;
    end

    // Configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            start_pc_q <= '0;
            stop_pc_q  <= '0;
        end else begin
            if (wr_ctrl_c) begin
                ctrl_q <= ctrl_t'(cfg_wdata[CTRL_WIDTH-1:0]);
            end
            if (wr_start_c) begin
                start_pc_q <= cfg_wdata;
            end
            if (wr_stop_c) begin
                stop_pc_q <= cfg_wdata;
            end
        end
    end

    // Forwarded item output: one-cycle valid pulse, payload holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_instr <= '0;
        end else begin
            trace_valid <= fwd_c;
            if (fwd_c) begin
                trace_pc    <= pc;
                trace_instr <= instr;
            end
        end
    end

    // Saturating statistics; CLEAR beats a coincident count event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_count     <= '0;
            fwd_count      <= '0;
            overflow_count <= '0;
        end else if (wr_clear_c) begin
            seen_count     <= '0;
            fwd_count      <= '0;
            overflow_count <= '0;
        end else begin
            if (item_c && (seen_count != CNT_MAX)) begin
                seen_count <= seen_count + COUNTER_WIDTH'(1);
            end
            if (fwd_c && (fwd_count != CNT_MAX)) begin
                fwd_count <= fwd_count + COUNTER_WIDTH'(1);
            end
            if (ovf_c && (overflow_count != CNT_MAX)) begin
                overflow_count <= overflow_count + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule
